// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, op decode helpers.
package mdu_seq_pkg;

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StRun,
        StFix,
        StDone
    } state_e;

    function automatic logic op_is_div(op_e op);
        return (op == OpDivu) || (op == OpDiv);
    endfunction

    function automatic logic op_is_signed(op_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/mdu_seq_addsub33.sv
// Add/subtract with carry out; the only arithmetic unit stepped during the iteration phase.
module mdu_seq_addsub33 #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W-1:0] w_b;
    logic [W:0]   w_res;

    // a + b, or a + ~b + 1; carry out of a subtract means a >= b (unsigned)
    always_comb begin
        w_b   = i_sub ? ~i_b : i_b;
        w_res = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};
    end

    assign o_sum  = w_res[W-1:0];
    assign o_cout = w_res[W];

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle HI/LO unit: shift-add multiply and restoring divide over WIDTH iterations,
// with sign fix-up, MTHI/MTLO writes, cancel and divide-by-zero reporting.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             ready,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = WIDTH + 1;
    localparam logic [WIDTH-1:0]   One  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] One2 = (2 * WIDTH)'(1);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;     // raw b, then |mcand| or |divisor| from PREP on
    logic [WIDTH-1:0] r_acc_hi;  // product high half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;  // multiplier -> product low half / dividend -> quotient
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_lo;  // negate product (mul) or quotient (div) in FIX
    logic             r_neg_hi;  // negate remainder in FIX
    logic             r_dz_pend;
    logic             r_busy;
    logic             r_ready;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_div;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [AW-1:0]    w_as_a;
    logic [AW-1:0]    w_as_b;
    logic             w_as_sub;
    logic [AW-1:0]    w_as_sum;
    logic             w_as_cout;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // Operand magnitudes and signs for the signed ops
    always_comb begin
        w_div    = op_is_div(r_op);
        w_sign_a = op_is_signed(r_op) & r_opa[WIDTH-1];
        w_sign_b = op_is_signed(r_op) & r_opb[WIDTH-1];
        w_abs_a  = w_sign_a ? (~r_opa + One) : r_opa;
        w_abs_b  = w_sign_b ? (~r_opb + One) : r_opb;
    end

    // Steer the shared adder: trial subtract for divide, conditional add for multiply
    always_comb begin
        w_as_a   = '0;
        w_as_b   = '0;
        w_as_sub = 1'b0;
        if (w_div) begin
            w_as_a   = {r_acc_hi, r_acc_lo[WIDTH-1]};
            w_as_b   = {1'b0, r_opb};
            w_as_sub = 1'b1;
        end else begin
            w_as_a   = {1'b0, r_acc_hi};
            w_as_b   = r_acc_lo[0] ? {1'b0, r_opb} : '0;
            w_as_sub = 1'b0;
        end
    end

    mdu_seq_addsub33 #(
        .W (AW)
    ) u_addsub (
        .i_a    (w_as_a),
        .i_b    (w_as_b),
        .i_sub  (w_as_sub),
        .o_sum  (w_as_sum),
        .o_cout (w_as_cout)
    );

    // Sign fix-up of the raw magnitude result
    always_comb begin
        w_prod_neg = ~{r_acc_hi, r_acc_lo} + One2;
        w_fix_hi   = r_acc_hi;
        w_fix_lo   = r_acc_lo;
        if (w_div) begin
            if (r_neg_lo) w_fix_lo = ~r_acc_lo + One;
            if (r_neg_hi) w_fix_hi = ~r_acc_hi + One;
        end else if (r_neg_lo) begin
            {w_fix_hi, w_fix_lo} = w_prod_neg;
        end
    end

    // Sequencer FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= StIdle;
            r_op      <= OpMultu;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_dz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_ready <= 1'b0;
            // MTHI/MTLO; a result written later in the same op overwrites these
            if (!r_busy) begin
                if (whi) r_hi <= wdata;
                if (wlo) r_lo <= wdata;
            end
            if (cancel) begin
                // Abort without touching hi/lo/dz; in IDLE this also drops start
                r_state <= StIdle;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start) begin
                            r_opa     <= a;
                            r_opb     <= b;
                            r_op      <= op_e'(op);
                            r_dz      <= 1'b0;
                            r_dz_pend <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= StPrep;
                        end
                    end
                    StPrep: begin
                        r_cnt    <= '0;
                        r_acc_hi <= '0;
                        r_neg_lo <= w_sign_a ^ w_sign_b;
                        if (w_div) begin
                            r_acc_lo <= w_abs_a;
                            r_opb    <= w_abs_b;
                            r_neg_hi <= w_sign_a;
                            if (r_opb == '0) begin
                                // Zero divisor skips RUN; FIX passes this result through unchanged
                                r_dz_pend <= 1'b1;
                                r_acc_hi  <= r_opa;
                                r_acc_lo  <= '1;
                                r_neg_lo  <= 1'b0;
                                r_neg_hi  <= 1'b0;
                                r_state   <= StFix;
                            end else begin
                                r_state <= StRun;
                            end
                        end else begin
                            r_acc_lo <= w_abs_b;
                            r_opb    <= w_abs_a;
                            r_neg_hi <= 1'b0;
                            r_state  <= StRun;
                        end
                    end
                    StRun: begin
                        if (w_div) begin
                            r_acc_hi <= w_as_cout ? w_as_sum[WIDTH-1:0] : w_as_a[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_as_cout};
                        end else begin
                            r_acc_hi <= w_as_sum[AW-1:1];
                            r_acc_lo <= {w_as_sum[0], r_acc_lo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= StFix;
                    end
                    StFix: begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_dz    <= r_dz_pend;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StDone;
                    end
                    StDone: begin
                        // start here is ignored; the next op begins from IDLE
                        r_state <= StIdle;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy  = r_busy;
    assign ready = r_ready;
    assign dz    = r_dz;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: driver pushes model results, monitor pops on ready.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         clrn;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         whi;
    logic         wlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         ready;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           rcyc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    mdu_seq #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .whi    (whi),
        .wlo    (wlo),
        .wdata  (wdata),
        .busy   (busy),
        .ready  (ready),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition
    function automatic void model(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] h, output logic [W-1:0] l,
                                  output logic d);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        d  = 1'b0;
        h  = '0;
        l  = '0;
        p  = '0;
        sx = $signed(x);
        sy = $signed(y);
        q  = 0;
        r  = 0;
        case (o)
            OpMultu: begin
                p = {32'h0, x} * {32'h0, y};
                h = p[63:32];
                l = p[31:0];
            end
            OpMult: begin
                p = sx * sy;
                h = p[63:32];
                l = p[31:0];
            end
            OpDivu, OpDiv: begin
                if (y == '0) begin
                    d = 1'b1;
                    h = x;
                    l = '1;
                end else if (o == OpDivu) begin
                    l = x / y;
                    h = x % y;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Start an op at the next edge and push the expected result; returns #1 after that edge
    task automatic issue(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string nm);
        exp_t         e;
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic         d;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(o, x, y, h, l, d);
        e.hi   = h;
        e.lo   = l;
        e.dz   = d;
        e.rcyc = cyc + (d ? 2 : W + 2);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until the monitor has consumed every pending result, then leave DONE
    task automatic wait_done(input string nm);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(posedge clk);
            #2;
            i++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Count ready pulses over a number of cycles
    task automatic watch_ready(input int ncyc, output int seen);
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen++;
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected result
    always @(posedge clk) begin
        #1;
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                check({mon_e.name, "_dz"}, 64'(dz), 64'(mon_e.dz));
                check({mon_e.name, "_lat"}, 64'(cyc), 64'(mon_e.rcyc));
                check({mon_e.name, "_busy"}, 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int           seen;
        op_e          ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        int unsigned  sel;
        exp_t         e;
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic         d;

        clrn   = 1'b0;
        start  = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        whi    = 1'b0;
        wlo    = 1'b0;
        wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_dz", 64'(dz), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        // Directed cases
        issue(OpMultu, 32'd7, 32'd6, "multu_7x6");
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid_run", 64'(busy), 64'd1);
        wait_done("multu_7x6");
        issue(OpMult, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
        wait_done("mult_m3x5");
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        wait_done("multu_max");
        issue(OpDiv, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        wait_done("div_m7_2");
        issue(OpDivu, 32'd100, 32'd7, "divu_100_7");
        wait_done("divu_100_7");
        issue(OpDivu, 32'd5, 32'd0, "divu_by_zero");
        wait_done("divu_by_zero");
        repeat (3) @(posedge clk);
        #1;
        check("dz_held", 64'(dz), 64'd1);
        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("dz_cleared_on_start", 64'(dz), 64'd0);
        wait_done("div_ovf");
        issue(OpDiv, 32'hFFFF_FFF9, 32'd0, "div_by_zero");
        wait_done("div_by_zero");

        // start while busy must be ignored
        issue(OpDivu, 32'd1000, 32'd33, "divu_start_busy");
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = OpMultu;
        a     = 32'd3;
        b     = 32'd3;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done("divu_start_busy");

        // MTHI / MTLO in IDLE
        @(negedge clk);
        whi   = 1'b1;
        wdata = 32'hAAAA_5555;
        @(negedge clk);
        whi   = 1'b0;
        wlo   = 1'b1;
        wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        wlo = 1'b0;
        check("mthi", 64'(hi), 64'hAAAA_5555);
        check("mtlo", 64'(lo), 64'h0F0F_0F0F);

        // Cancel at RUN cycle 10, with an MTHI attempt while busy
        @(negedge clk);
        start = 1'b1;
        op    = OpMultu;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        whi   = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        whi = 1'b0;
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hi_kept", 64'(hi), 64'hAAAA_5555);
        check("cancel_lo_kept", 64'(lo), 64'h0F0F_0F0F);

        // cancel together with start in IDLE drops the start
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = OpDivu;
        a      = 32'd50;
        b      = 32'd5;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_start_idle_busy", 64'(busy), 64'd0);
        watch_ready(45, seen);
        check("cancel_no_ready", 64'(seen), 64'd0);

        // MTHI with start in IDLE: write now, result overwrites later
        @(negedge clk);
        start = 1'b1;
        op    = OpDivu;
        a     = 32'd100;
        b     = 32'd7;
        whi   = 1'b1;
        wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        start = 1'b0;
        whi   = 1'b0;
        check("mthi_with_start", 64'(hi), 64'h55);
        model(OpDivu, 32'd100, 32'd7, h, l, d);
        e.hi   = h;
        e.lo   = l;
        e.dz   = d;
        e.rcyc = cyc + W + 2;
        e.name = "divu_after_mthi";
        exp_q.push_back(e);
        wait_done("divu_after_mthi");

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start = 1'b1;
        op    = OpMult;
        a     = 32'h1234_5678;
        b     = 32'hFFFF_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        check("clrn_mid_outputs", 64'({busy, ready, dz, hi, lo}), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        watch_ready(45, seen);
        check("clrn_no_ready", 64'(seen), 64'd0);
        issue(OpMultu, 32'd7, 32'd6, "multu_after_clrn");
        wait_done("multu_after_clrn");

        // Randomized operations
        for (int t = 0; t < 60; t++) begin
            ro  = op_e'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                ry = '0;
            end else if (sel < 3) begin
                rx = $urandom_range(0, 1000);
                ry = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) rx = ~rx + 32'd1;
                if ($urandom_range(0, 1) == 1) ry = ~ry + 32'd1;
            end else if (sel == 3) begin
                rx = 32'h8000_0000;
            end
            issue(ro, rx, ry, "rand");
            wait_done("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
